// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arbState_t : arbiter FSM encoding (IDLE / BUSY / RESP)
//   reqId_t    : requester identity (CPU controller / debug-loader port)
//   ARB_TO_DEFAULT : default memory-latency watchdog limit in cycles
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arbState_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } reqId_t;

  localparam int ARB_TO_DEFAULT = 15;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   req0, req1  : pending requests (0 = CPU, 1 = debug)
//   last        : requester that won the most recent contested grant
//   grant_valid : at least one request is pending
//   grant_id    : requester to serve; on a tie the one that is not 'last'
module rr_pick2
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = (last == REQ_DBG) ? REQ_CPU : REQ_DBG;
    end else begin
      grant_id = req1 ? REQ_DBG : REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified instruction/data memory between the CPU
// controller (requester 0) and the debug/loader port (requester 1).
// One access at a time: IDLE -> BUSY (mem_req held) -> RESP (one-cycle ack).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack          : CPU read data + one-cycle completion pulse
//   cpu_stall                   : cpu_req & ~cpu_ack, freezes the controller
//   dbg_req/we/addr/wdata       : debug request, held until dbg_ack
//   dbg_rdata, dbg_ack          : debug read data + completion pulse
//   mem_req/we/addr/wdata       : registered memory command
//   mem_rdata, mem_ready        : memory response
//   err                         : pulses with the ack when the watchdog fired
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO = ARB_TO_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  // Final BUSY cycle index before the watchdog forces completion.
  localparam logic [7:0] TIMER_LAST = 8'(TO - 1);

  arbState_t     state;
  reqId_t        last;
  reqId_t        winner;
  logic [7:0]    timer;
  logic          grantValid;
  logic          grantId;
  logic          finish;
  logic [DW-1:0] respData;

  rr_pick2 uPick (
    .req0        (cpu_req),
    .req1        (dbg_req),
    .last        (last),
    .grant_valid (grantValid),
    .grant_id    (grantId)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;

  // A ready in the expiry cycle wins over the watchdog, so only a missing
  // ready produces the zeroed error response.
  assign finish   = mem_ready || (timer == TIMER_LAST);
  assign respData = mem_ready ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      last      <= REQ_DBG;
      winner    <= REQ_CPU;
      timer     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      err       <= 1'b0;
    end else begin
      // Acks and err are single-cycle pulses that live only in RESP.
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      err     <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grantValid) begin
            winner <= reqId_t'(grantId);
            if (cpu_req && dbg_req) begin
              last <= reqId_t'(grantId);
            end
            if (grantId == REQ_DBG) begin
              mem_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            mem_req <= 1'b1;
            timer   <= '0;
            state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (finish) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= ~mem_ready;
            if (winner == REQ_CPU) begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= respData;
            end else begin
              dbg_ack   <= 1'b1;
              dbg_rdata <= respData;
            end
            state <= ARB_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset abort, zero-wait read,
// contention ordering, write with wait states, watchdog timeout and the
// expiry-cycle / idle-ready boundaries.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_ack, cpu_stall, dbg_ack;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic expCpu, expDbg;

    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_err", err, 0);

    // T1: asynchronous abort in the middle of BUSY
    @(negedge clk); rst_n = 1'b1;
    cpu_req = 1; cpu_addr = 32'h10;
    tick();
    chk("t1_busy_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_abort_req", mem_req, 0);
    chk("t1_abort_ack", cpu_ack, 0);
    chk("t1_abort_err", err, 0);
    chk("t1_abort_addr", mem_addr, 0);
    cpu_req = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    tick();
    chk("t1_idle_req", mem_req, 0);
    chk("t1_idle_ack", cpu_ack, 0);

    // T2: CPU read, zero wait state
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    #1 chk("t2_stall_n", cpu_stall, 1);
    tick();
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_addr", mem_addr, 32'h40);
    chk("t2_mem_we", mem_we, 0);
    chk("t2_stall_n1", cpu_stall, 1);
    mem_ready = 1; mem_rdata = 32'h1234ABCD;
    tick();
    chk("t2_ack", cpu_ack, 1);
    chk("t2_rdata", cpu_rdata, 32'h1234ABCD);
    chk("t2_err", err, 0);
    chk("t2_mem_req_drop", mem_req, 0);
    chk("t2_stall_off", cpu_stall, 0);
    chk("t2_dbg_ack", dbg_ack, 0);
    cpu_req = 0; mem_ready = 0;
    tick();
    chk("t2_ack_pulse", cpu_ack, 0);
    chk("t2_rdata_hold", cpu_rdata, 32'h1234ABCD);

    // T3: both requesters held from reset, memory always ready
    rst_n = 1'b0;
    cpu_req = 1; cpu_addr = 32'h100;
    dbg_req = 1; dbg_addr = 32'h200;
    mem_ready = 1; mem_rdata = 32'hA5;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      expCpu = (k % 3 == 2) && ((k / 3) % 2 == 0);
      expDbg = (k % 3 == 2) && ((k / 3) % 2 == 1);
      chk($sformatf("t3_cpu_ack_%0d", k), cpu_ack, expCpu);
      chk($sformatf("t3_dbg_ack_%0d", k), dbg_ack, expDbg);
      if (k % 3 == 1)
        chk($sformatf("t3_addr_%0d", k), mem_addr, ((k / 3) % 2 == 0) ? 32'h100 : 32'h200);
    end
    cpu_req = 0; dbg_req = 0; mem_ready = 0;
    tick();

    // T4: debug write with four BUSY cycles
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h8; dbg_wdata = 32'hFF;
    mem_rdata = 32'h77;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_req_%0d", i), mem_req, 1);
      chk($sformatf("t4_we_%0d", i), mem_we, 1);
      chk($sformatf("t4_wdata_%0d", i), mem_wdata, 32'hFF);
      chk($sformatf("t4_ack_%0d", i), dbg_ack, 0);
      if (i == 3) mem_ready = 1;
      tick();
    end
    chk("t4_dbg_ack", dbg_ack, 1);
    chk("t4_err", err, 0);
    chk("t4_cpu_ack", cpu_ack, 0);
    chk("t4_dbg_rdata", dbg_rdata, 32'h77);
    dbg_req = 0; dbg_we = 0; mem_ready = 0;
    tick();

    // T5: watchdog timeout on a CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44; mem_rdata = 32'hDEAD;
    tick();
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("t5_busy_cycles", cnt, 15);
    chk("t5_ack", cpu_ack, 1);
    chk("t5_err", err, 1);
    chk("t5_rdata_zero", cpu_rdata, 0);
    chk("t5_dbg_rdata_hold", dbg_rdata, 32'h77);
    cpu_req = 0;
    tick();
    chk("t5_err_pulse", err, 0);
    cpu_req = 1; cpu_addr = 32'h48;
    tick();
    chk("t5_next_addr", mem_addr, 32'h48);
    mem_ready = 1; mem_rdata = 32'h55;
    tick();
    chk("t5_next_ack", cpu_ack, 1);
    chk("t5_next_rdata", cpu_rdata, 32'h55);
    chk("t5_next_err", err, 0);
    cpu_req = 0; mem_ready = 0;
    tick();

    // T6: ready arrives in the expiry cycle; ready while idle is ignored
    cpu_req = 1; cpu_addr = 32'h4C;
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("t6_still_busy", mem_req, 1);
    chk("t6_no_ack_yet", cpu_ack, 0);
    mem_ready = 1; mem_rdata = 32'hCAFE;
    tick();
    chk("t6_ack", cpu_ack, 1);
    chk("t6_err", err, 0);
    chk("t6_rdata", cpu_rdata, 32'hCAFE);
    cpu_req = 0; mem_ready = 0;
    tick();
    mem_ready = 1; mem_rdata = 32'hBAD;
    tick();
    tick();
    chk("t6_idle_req", mem_req, 0);
    chk("t6_idle_cpu_ack", cpu_ack, 0);
    chk("t6_idle_dbg_ack", dbg_ack, 0);
    chk("t6_idle_rdata", cpu_rdata, 32'hCAFE);
    mem_ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
